// File: rtl/ysyx_25060170_isram.sv
// AXI4-Lite-style SRAM responder for the core's fetch/load-store bus.
// One transaction in flight, with a programmable response latency.
module ysyx_25060170_isram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT    = 4'(LATENCY);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        rd_acc;
  logic        wait_done;
  logic        rd_load;
  logic        wr_commit;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  // Subtraction wraps, so addresses below the base land far out of range.
  function automatic logic hit(input logic [31:0] a);
    return (a - ADDR_BASE) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] index(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  assign arready   = rst && (state == IDLE);
  assign awready   = arready && awvalid && wvalid && !arvalid;
  assign wready    = awready;
  assign rd_acc    = arvalid && arready;
  assign wait_done = (cnt <= 4'd1);

  // With zero latency the response is loaded straight from the bus inputs.
  assign rd_addr   = (state == IDLE) ? araddr : addr_q;
  assign wr_addr   = (state == IDLE) ? awaddr : addr_q;
  assign wr_data   = (state == IDLE) ? wdata  : wdata_q;
  assign wr_strb   = (state == IDLE) ? wstrb  : wstrb_q;

  assign rd_load   = (rd_acc && (LAT == 4'd0)) || ((state == RD_WAIT) && wait_done);
  assign wr_commit = (awready && (LAT == 4'd0)) || (rst && (state == WR_WAIT) && wait_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (rd_acc) begin
            addr_q <= araddr;
            cnt    <= LAT;
            state  <= (LAT == 4'd0) ? RD_RESP : RD_WAIT;
          end else if (awready) begin
            addr_q  <= awaddr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            cnt     <= LAT;
            state   <= (LAT == 4'd0) ? WR_RESP : WR_WAIT;
          end
        end
        RD_WAIT: begin
          cnt   <= wait_done ? 4'd0 : cnt - 4'd1;
          state <= wait_done ? RD_RESP : RD_WAIT;
        end
        WR_WAIT: begin
          cnt   <= wait_done ? 4'd0 : cnt - 4'd1;
          state <= wait_done ? WR_RESP : WR_WAIT;
        end
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= OKAY;
            state  <= IDLE;
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            bresp  <= OKAY;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (rd_load) begin
        rvalid <= 1'b1;
        rdata  <= hit(rd_addr) ? mem[index(rd_addr)] : '0;
        rresp  <= hit(rd_addr) ? OKAY : DECERR;
      end
      if (wr_commit) begin
        bvalid <= 1'b1;
        bresp  <= hit(wr_addr) ? OKAY : DECERR;
      end
    end
  end

  // Array is deliberately not reset; the commit is gated by rst above.
  always_ff @(posedge clk) begin
    if (wr_commit && hit(wr_addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[index(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule
